// File: rtl/accum_arbiter.sv
//------------------------------------------------------------------------------
// accum_arbiter
//
// Round-robin arbiter and sequencer that shares one accumulator datapath
// between NUM_REQ requesters. One requester is granted at a time. Its operand
// is driven to the accumulator, and the arbiter waits for the accumulator's
// done handshake. The post-add accumulated value is then returned to the
// winner with a one-cycle ack. Clear commands are serialised through the same
// sequencer. An accumulator that never answers is aborted after TIMEOUT cycles
// and flagged.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   ACCUM_WIDTH  operand/result width, equal to the accumulator width
//   TIMEOUT      max cycles acc_en is held without acc_done (>= 2)
//
// Ports:
//   clk          clock
//   reset_l      asynchronous active-low reset
//   req          per-requester request level, held until the matching ack
//   add_in       flattened operands, slice i belongs to req[i]
//   ack          one-cycle completion pulse to the granted requester
//   result       accumulated value after the add (valid with ack)
//   resp_err     qualifies ack: 1 = timed out, result is 0
//   clr_req      clear request level, held until clr_ack
//   clr_ack      one-cycle pulse when the clear has completed
//   acc_en       accumulator enable
//   acc_add      accumulator operand
//   acc_clr_l    active-low accumulator clear
//   acc_accum    accumulator current value
//   acc_done     accumulator completion flag
//   timeout_err  sticky: a transaction has timed out since reset
//------------------------------------------------------------------------------
module accum_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ACCUM_WIDTH = 124,
   parameter int TIMEOUT     = 16
) (
   input  logic                           clk,
   input  logic                           reset_l,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*ACCUM_WIDTH-1:0] add_in,
   output logic [NUM_REQ-1:0]             ack,
   output logic [ACCUM_WIDTH-1:0]         result,
   output logic                           resp_err,
   input  logic                           clr_req,
   output logic                           clr_ack,
   output logic                           acc_en,
   output logic [ACCUM_WIDTH-1:0]         acc_add,
   output logic                           acc_clr_l,
   input  logic [ACCUM_WIDTH-1:0]         acc_accum,
   input  logic                           acc_done,
   output logic                           timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_COMPLETE = 3'd2;
   localparam logic [2:0] S_DRAIN    = 3'd3;
   localparam logic [2:0] S_CLEAR    = 3'd4;

   // Requester index base+off, wrapped into 0..NUM_REQ-1.
   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int off);
      int sum;
      sum = int'(base) + off;
      sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
      return IDX_W'(sum);
   endfunction

   // One-hot vector with bit idx set.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   logic [2:0]             state_q, state_d;
   logic [IDX_W-1:0]       rr_q, rr_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [ACCUM_WIDTH-1:0] result_q, result_d;
   logic                   resp_err_q, resp_err_d;
   logic                   clr_ack_q, clr_ack_d;
   logic                   acc_en_q, acc_en_d;
   logic [ACCUM_WIDTH-1:0] acc_add_q, acc_add_d;
   logic                   acc_clr_l_q, acc_clr_l_d;
   logic                   timeout_err_q, timeout_err_d;

   logic                   pick_valid_s;
   logic [IDX_W-1:0]       pick_idx_s;
   logic [ACCUM_WIDTH-1:0] pick_add_s;

   // Round-robin pick: first asserted request at or after rr_q, wrapping.
   always_comb begin
      logic             hit;
      logic [IDX_W-1:0] cand;
      pick_valid_s = 1'b0;
      pick_idx_s   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand         = wrap_idx(rr_q, off);
         hit          = ~pick_valid_s & req[cand];
         pick_idx_s   = hit ? cand : pick_idx_s;
         pick_valid_s = pick_valid_s | hit;
      end
   end

   // Operand mux for the picked requester.
   always_comb begin
      pick_add_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pick_add_s = (pick_idx_s == IDX_W'(i)) ?
                      add_in[i*ACCUM_WIDTH +: ACCUM_WIDTH] : pick_add_s;
      end
   end

   // Sequencer next-state and registered-output next values.
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      ack_d         = '0;
      result_d      = result_q;
      resp_err_d    = 1'b0;
      clr_ack_d     = 1'b0;
      acc_en_d      = acc_en_q;
      acc_add_d     = acc_add_q;
      acc_clr_l_d   = 1'b1;
      timeout_err_d = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               // Clear always wins over pending requests.
               acc_clr_l_d = 1'b0;
               state_d     = S_CLEAR;
            end else if (pick_valid_s) begin
               grant_d   = pick_idx_s;
               acc_add_d = pick_add_s;
               acc_en_d  = 1'b1;
               cnt_d     = '0;
               state_d   = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ISSUE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (acc_done) begin
               result_d = acc_accum;
               ack_d    = onehot(grant_q);
               acc_en_d = 1'b0;
               state_d  = S_DRAIN;
            end else if (cnt_q == CNT_LAST) begin
               // Abort: acc_en has been high for TIMEOUT cycles with no answer.
               result_d      = '0;
               ack_d         = onehot(grant_q);
               resp_err_d    = 1'b1;
               timeout_err_d = 1'b1;
               acc_en_d      = 1'b0;
               state_d       = S_DRAIN;
            end else begin
               state_d = S_ISSUE;
            end
         end

         S_DRAIN: begin
            if (!acc_done) begin
               rr_d    = wrap_idx(grant_q, 1);
               // A winner whose req is still up gets one extra cycle to drop
               // it so it cannot be granted twice for one request.
               state_d = req[grant_q] ? S_COMPLETE : S_IDLE;
            end else begin
               state_d = S_DRAIN;
            end
         end

         S_CLEAR: begin
            clr_ack_d = 1'b1;
            state_d   = S_COMPLETE;
         end

         S_COMPLETE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d  = S_IDLE;
            acc_en_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q       <= S_IDLE;
         rr_q          <= '0;
         grant_q       <= '0;
         cnt_q         <= '0;
         ack_q         <= '0;
         result_q      <= '0;
         resp_err_q    <= 1'b0;
         clr_ack_q     <= 1'b0;
         acc_en_q      <= 1'b0;
         acc_add_q     <= '0;
         acc_clr_l_q   <= 1'b1;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         grant_q       <= grant_d;
         cnt_q         <= cnt_d;
         ack_q         <= ack_d;
         result_q      <= result_d;
         resp_err_q    <= resp_err_d;
         clr_ack_q     <= clr_ack_d;
         acc_en_q      <= acc_en_d;
         acc_add_q     <= acc_add_d;
         acc_clr_l_q   <= acc_clr_l_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign ack         = ack_q;
   assign result      = result_q;
   assign resp_err    = resp_err_q;
   assign clr_ack     = clr_ack_q;
   assign acc_en      = acc_en_q;
   assign acc_add     = acc_add_q;
   assign acc_clr_l   = acc_clr_l_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_accum_arbiter.sv
`timescale 1ns/1ps
module tb_accum_arbiter;
   localparam int N  = 4;
   localparam int W  = 124;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           reset_l;
   logic [N-1:0]   req;
   logic [N*W-1:0] add_in;
   logic [N-1:0]   ack;
   logic [W-1:0]   result;
   logic           resp_err;
   logic           clr_req;
   logic           clr_ack;
   logic           acc_en;
   logic [W-1:0]   acc_add;
   logic           acc_clr_l;
   logic [W-1:0]   acc_accum;
   logic           acc_done;
   logic           timeout_err;

   always #5 clk = ~clk;

   accum_arbiter #(.NUM_REQ(N), .ACCUM_WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_l(reset_l), .req(req), .add_in(add_in), .ack(ack),
      .result(result), .resp_err(resp_err), .clr_req(clr_req), .clr_ack(clr_ack),
      .acc_en(acc_en), .acc_add(acc_add), .acc_clr_l(acc_clr_l),
      .acc_accum(acc_accum), .acc_done(acc_done), .timeout_err(timeout_err)
   );

   // Accumulator model; 'alive' = 0 makes it never answer.
   logic         alive;
   logic [W-1:0] mval_q;
   logic         mdone_q;
   assign acc_done  = mdone_q | (acc_en & alive);
   assign acc_accum = mdone_q ? mval_q : mval_q + acc_add;
   always @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         mval_q <= '0; mdone_q <= 1'b0;
      end else if (!acc_clr_l) begin
         mval_q <= '0; mdone_q <= 1'b0;
      end else if (acc_en && !mdone_q && alive) begin
         mval_q <= mval_q + acc_add; mdone_q <= 1'b1;
      end else if (!acc_en) begin
         mdone_q <= 1'b0;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [W-1:0] ref_acc;
   int           ref_rr;
   bit           in_flight;
   int           exp_idx;
   logic [W-1:0] exp_op;
   int           en_cycles;
   bit           prev_en;
   bit           clr_expect;
   bit           ref_terr;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] oh(input int k);
      logic [N-1:0] v;
      v = '0; v[k] = 1'b1;
      return v;
   endfunction

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int off = 0; off < N; off++)
         if (r[(p + off) % N]) return (p + off) % N;
      return -1;
   endfunction

   function automatic logic [W-1:0] slice(input int k);
      return add_in[k*W +: W];
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
         0:       return W'($urandom_range(0, 100));
         1:       return {W{1'b1}} - W'($urandom_range(0, 3));
         default: return t[W-1:0];
      endcase
   endfunction

   task automatic set_op(input int k, input logic [W-1:0] v);
      add_in[k*W +: W] = v;
   endtask

   // Checks the DUT against the arbitration/accumulation rules each cycle.
   task automatic monitor();
      if (reset_l) begin
         if (acc_en && !prev_en) begin
            int w;
            w = pick(req, ref_rr);
            check("grant_has_req", W'(w >= 0), W'(1));
            if (w < 0) w = 0;
            check("clear_priority", W'(clr_req), W'(0));
            check("grant_while_busy", W'(in_flight), W'(0));
            check("grant_operand", acc_add, slice(w));
            in_flight = 1'b1; exp_idx = w; exp_op = slice(w); en_cycles = 0;
         end
         if (acc_en) en_cycles++;
         if (ack != '0) begin
            check("ack_expected", W'(in_flight), W'(1));
            check("ack_winner", W'(ack), W'(oh(exp_idx)));
            check("acc_en_low_at_ack", W'(acc_en), W'(0));
            if (alive) begin
               ref_acc = ref_acc + exp_op;
               check("model_result", result, ref_acc);
               check("model_resp_err", W'(resp_err), W'(0));
            end else begin
               ref_terr = 1'b1;
               check("model_to_result", result, W'(0));
               check("model_to_resp_err", W'(resp_err), W'(1));
               check("model_to_en_cycles", W'(en_cycles), W'(TO));
            end
            check("model_timeout_err", W'(timeout_err), W'(ref_terr));
            ref_rr = (exp_idx + 1) % N;
            in_flight = 1'b0;
         end
         if (clr_expect || clr_ack) check("model_clr_ack", W'(clr_ack), W'(clr_expect));
         clr_expect = !acc_clr_l;
         if (!acc_clr_l) begin
            check("clear_requested", W'(clr_req), W'(1));
            check("clear_while_busy", W'(in_flight), W'(0));
            ref_acc = '0;
         end
         prev_en = acc_en;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset_l = 1'b0; req = '0; clr_req = 1'b0; alive = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_l = 1'b1;
      ref_acc = '0; ref_rr = 0; in_flight = 1'b0; prev_en = 1'b0;
      clr_expect = 1'b0; ref_terr = 1'b0; en_cycles = 0;
   endtask

   task automatic wait_ack(output logic [N-1:0] got, output logic [W-1:0] res,
                           output logic err, output int lat);
      got = '0; res = '0; err = 1'b0; lat = 0;
      while (got == '0 && lat < 60) begin
         tick();
         lat++;
         if (ack != '0) begin got = ack; res = result; err = resp_err; end
      end
      if (got == '0) begin
         n_checks++; n_fail++;
         $display("FAIL ack_wait: no ack within %0d cycles", lat);
      end
      req = req & ~got;
   endtask

   typedef struct {
      int           idx;
      logic [W-1:0] op;
      bit           alive;
      logic [W-1:0] exp_res;
      bit           exp_err;
      int           exp_lat;
   } vec_t;

   vec_t         vt[5];
   logic [N-1:0] got;
   logic [W-1:0] res;
   logic         err;
   int           lat;
   int           exp_b[4];
   int           cnt;
   logic [N-1:0] seen;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_l = 1'b0; req = '0; clr_req = 1'b0; add_in = '0; alive = 1'b1;
      do_reset();

      // Reset values
      check("rst_ack", W'(ack), W'(0));
      check("rst_result", result, W'(0));
      check("rst_resp_err", W'(resp_err), W'(0));
      check("rst_clr_ack", W'(clr_ack), W'(0));
      check("rst_acc_en", W'(acc_en), W'(0));
      check("rst_acc_add", acc_add, W'(0));
      check("rst_acc_clr_l", W'(acc_clr_l), W'(1));
      check("rst_timeout_err", W'(timeout_err), W'(0));

      // Single request, minimum latency
      set_op(0, W'(5)); req[0] = 1'b1;
      tick();
      check("A_acc_en_rise", W'(acc_en), W'(1));
      check("A_no_early_ack", W'(ack), W'(0));
      tick();
      check("A_ack", W'(ack), W'(4'b0001));
      check("A_result", result, W'(5));
      check("A_resp_err", W'(resp_err), W'(0));
      req[0] = 1'b0;
      tick();
      check("A_acc_en_low", W'(acc_en), W'(0));
      idle(4);

      // Table vectors: state continues from acc=5, rr=1
      vt[0] = '{1, W'(10),   1'b1, W'(15), 1'b0, 2};
      vt[1] = '{3, {W{1'b1}}, 1'b1, W'(14), 1'b0, 2};
      vt[2] = '{0, W'(7),    1'b0, W'(0),  1'b1, TO + 1};
      vt[3] = '{2, W'(3),    1'b1, W'(17), 1'b0, 2};
      vt[4] = '{2, W'(1),    1'b1, W'(18), 1'b0, 2};
      for (int i = 0; i < 5; i++) begin
         alive = vt[i].alive;
         set_op(vt[i].idx, vt[i].op);
         req[vt[i].idx] = 1'b1;
         wait_ack(got, res, err, lat);
         check("T_ack", W'(got), W'(oh(vt[i].idx)));
         check("T_result", res, vt[i].exp_res);
         check("T_resp_err", W'(err), W'(vt[i].exp_err));
         check("T_latency", W'(lat), W'(vt[i].exp_lat));
         idle(4);
      end
      alive = 1'b1;

      // All four requesters at once from rr pointer 0
      do_reset();
      exp_b = '{1, 3, 6, 10};
      for (int k = 0; k < N; k++) set_op(k, W'(k + 1));
      req = 4'b1111;
      for (int i = 0; i < N; i++) begin
         wait_ack(got, res, err, lat);
         check("B_order", W'(got), W'(oh(i)));
         check("B_result", res, W'(exp_b[i]));
      end
      idle(4);

      // Clear and request together: clear first
      clr_req = 1'b1; set_op(2, W'(7)); req[2] = 1'b1;
      tick();
      check("C_clr_low", W'(acc_clr_l), W'(0));
      check("C_no_clr_ack_yet", W'(clr_ack), W'(0));
      tick();
      check("C_clr_high", W'(acc_clr_l), W'(1));
      check("C_clr_ack", W'(clr_ack), W'(1));
      clr_req = 1'b0;
      tick();
      check("C_clr_ack_pulse", W'(clr_ack), W'(0));
      wait_ack(got, res, err, lat);
      check("C_ack", W'(got), W'(4'b0100));
      check("C_result", res, W'(7));
      idle(4);

      // Wrap-around: clear, then all-ones, then 2 -> 1
      clr_req = 1'b1;
      cnt = 0;
      while (!clr_ack && cnt < 20) begin tick(); cnt++; end
      check("D_clr_ack_seen", W'(clr_ack), W'(1));
      clr_req = 1'b0;
      set_op(1, {W{1'b1}}); req[1] = 1'b1;
      wait_ack(got, res, err, lat);
      check("D_result_ones", res, {W{1'b1}});
      set_op(1, W'(2)); req[1] = 1'b1;
      wait_ack(got, res, err, lat);
      check("D_ack", W'(got), W'(4'b0010));
      check("D_result_wrap", res, W'(1));
      check("D_resp_err", W'(err), W'(0));
      idle(4);

      // Timeout: accumulator never answers
      alive = 1'b0; set_op(3, W'(9)); req[3] = 1'b1;
      cnt = 0; got = '0; lat = 0;
      while (got == '0 && lat < 60) begin
         tick(); lat++;
         if (acc_en) cnt++;
         if (ack != '0) begin got = ack; res = result; err = resp_err; end
      end
      req[3] = 1'b0;
      check("E_en_cycles", W'(cnt), W'(TO));
      check("E_ack", W'(got), W'(4'b1000));
      check("E_resp_err", W'(err), W'(1));
      check("E_result", res, W'(0));
      check("E_timeout_err", W'(timeout_err), W'(1));
      idle(3);
      alive = 1'b1; set_op(1, W'(4)); req[1] = 1'b1;
      wait_ack(got, res, err, lat);
      check("E_next_result", res, W'(5));
      check("E_next_resp_err", W'(err), W'(0));
      check("E_sticky", W'(timeout_err), W'(1));
      idle(4);

      // Reset during ISSUE
      alive = 1'b0; set_op(2, W'(9)); req[2] = 1'b1;
      idle(3);
      check("F_in_issue", W'(acc_en), W'(1));
      #2 reset_l = 1'b0;
      #1;
      check("F_async_acc_en", W'(acc_en), W'(0));
      check("F_async_ack", W'(ack), W'(0));
      check("F_async_acc_add", acc_add, W'(0));
      check("F_async_acc_clr_l", W'(acc_clr_l), W'(1));
      check("F_async_timeout_err", W'(timeout_err), W'(0));
      check("F_async_result", result, W'(0));
      do_reset();
      seen = '0;
      for (int i = 0; i < 10; i++) begin tick(); seen = seen | ack; end
      check("F_no_ack_after_reset", W'(seen), W'(0));
      set_op(1, W'(6)); set_op(3, W'(8)); req = 4'b1010;
      wait_ack(got, res, err, lat);
      check("F_rr_zero", W'(got), W'(4'b0010));
      check("F_result", res, W'(6));
      wait_ack(got, res, err, lat);
      check("F_second", W'(got), W'(4'b1000));
      check("F_second_result", res, W'(14));
      idle(4);

      // Randomised traffic against the reference model
      for (int c = 0; c < 1500; c++) begin
         tick();
         req = req & ~ack;
         if (clr_ack) clr_req = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!req[k] && !ack[k] && $urandom_range(0, 3) == 0) begin
               set_op(k, rand_op());
               req[k] = 1'b1;
            end
         end
         if (!clr_req && !clr_ack && $urandom_range(0, 49) == 0) clr_req = 1'b1;
         if (!in_flight && !acc_en) alive = ($urandom_range(0, 7) != 0);
      end
      cnt = 0;
      while ((req != '0 || clr_req || in_flight) && cnt < 300) begin
         tick(); cnt++;
         req = req & ~ack;
         if (clr_ack) clr_req = 1'b0;
      end
      check("R_drained", W'(req != '0 || clr_req || in_flight), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/accum_arbiter.md
Name: accum_arbiter

Overview:
Round-robin arbiter and sequencer sharing one accumulator datapath between NUM_REQ requesters. It grants one requester at a time and drives the accumulator's enable/operand/clear interface. It waits for the accumulator's done handshake, then returns the post-add accumulated value to the winner. It also serialises clear commands and flags accumulators that never answer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ACCUM_WIDTH, 124, operand/result width; matches accumulator width
TIMEOUT, 16, max cycles acc_en may be held without acc_done before abort (>=2)

Ports:
clk  input  1  clock
reset_l  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level; held until matching ack
add_in  input  NUM_REQ*ACCUM_WIDTH  flattened operands; slice i belongs to req[i]; stable while req[i]
ack  output  NUM_REQ  one-cycle completion pulse to granted requester
result  output  ACCUM_WIDTH  accumulated value after the add; valid only with ack
resp_err  output  1  qualifies ack: 1 = transaction timed out, result is 0
clr_req  input  1  request to clear accumulator; level, held until clr_ack
clr_ack  output  1  one-cycle pulse when clear completed
acc_en  output  1  accumulator enable
acc_add  output  ACCUM_WIDTH  accumulator operand
acc_clr_l  output  1  active-low accumulator clear (to accumulator reset_l)
acc_accum  input  ACCUM_WIDTH  accumulator current value
acc_done  input  1  accumulator completion flag
timeout_err  output  1  sticky: any transaction timed out since reset

Behaviour:
- Clock clk, one domain; reset is asynchronous and active-low on reset_l. Every output is registered.
- Reset values: ack=0, result=0, resp_err=0, clr_ack=0, acc_en=0, acc_add=0, acc_clr_l=1, timeout_err=0. State=IDLE, rr pointer=0, timeout counter=0.
- Accumulator contract:
  - On the first acc_en cycle, the accumulator adds acc_add and raises acc_done.
  - acc_accum is the updated value in the same cycle acc_done is first seen high.
  - acc_done stays high until acc_en falls, then drops.
  - acc_clr_l low for one cycle zeroes the value and drops acc_done.
- FSM states: IDLE, ISSUE, COMPLETE, DRAIN, CLEAR.
- IDLE:
  - If clr_req=1: go to CLEAR. Clear has priority over all req.
  - Else if any req: grant the first set bit at or after the rr pointer, searching upward with wrap. Latch grant index and add_in slice into acc_add, set acc_en=1, clear the counter, go to ISSUE.
- ISSUE: acc_en held, counter increments each cycle.
  - If acc_done=1: latch result=acc_accum, pulse ack[grant]=1 with resp_err=0, drop acc_en, go to DRAIN.
  - Else if counter reaches TIMEOUT-1: drop acc_en, result=0, pulse ack[grant] with resp_err=1, set timeout_err, go to DRAIN.
- DRAIN:
  - Wait for acc_done=0, then go to IDLE.
  - Set rr pointer to grant+1 (mod NUM_REQ) on exit.
  - Requests and clears are not accepted in DRAIN.
- CLEAR: acc_clr_l=0 for exactly one cycle, then clr_ack pulse the following cycle, then IDLE.
- COMPLETE: one-cycle bubble after a clear, and the state IDLE waits in when a req from the previous winner is still high on the ack cycle. Each ack'd req needs one cycle to drop, so the same requester is never double-granted.
- Minimum latency: req high to ack = 2 cycles (grant edge, done edge). Back-to-back transactions have a gap of at least 1 DRAIN cycle.
- req dropped before ack: illegal. The transaction still completes and the ack is still pulsed.
- ACCUM_WIDTH arithmetic is done in the accumulator. Wrap-around modulo 2^ACCUM_WIDTH is passed through unchanged.
- reset_l assert mid-transaction: immediate return to reset values. The abandoned ack is never issued.

Test Plan:
- Single req[0], add_in[0]=5, fresh accumulator -> acc_en rises 1 cycle after req; ack[0] 2 cycles after req, result=5, resp_err=0; acc_en low after ack.
- req[0..3] all held, operands 1,2,3,4 -> grants in order 0,1,2,3; results 1,3,6,10; each ack one-hot; none repeated before all served.
- clr_req and req[2] asserted together in IDLE -> acc_clr_l low one cycle, clr_ack next cycle; then req[2] with add 7 gives result=7.
- Accumulator model holding acc_done=0, TIMEOUT=16 -> acc_en held 16 cycles then drops; ack with resp_err=1, result=0; timeout_err stays 1 until reset.
- Operand 2^124-1 then 2 -> second result=1 (wrap), resp_err=0.
- reset_l low during ISSUE -> all outputs at reset values asynchronously; no ack after release; next req served normally from rr pointer 0.
